// File: rtl/counter_mon_pkg.sv
// Shared types and constants for the counter monitor.
package counter_mon_pkg;

   // Default width of the observed counter value
   localparam int unsigned DEFAULT_WIDTH = 8;

   // Mismatch counter width and its saturation value
   localparam int unsigned ERR_COUNT_WIDTH = 8;
   localparam logic [ERR_COUNT_WIDTH-1:0] ERR_COUNT_MAX = '1;

   // Monitor phases: post-reset zero check, steady tracking, one-cycle resync
   typedef enum logic [1:0] {
      RST_CHK = 2'd0,
      TRACK   = 2'd1,
      RESYNC  = 2'd2
   } mon_state_e;

endpackage

// File: rtl/counter_monitor_if.sv
// Observation/result bundle between a counter under check and its monitor.
// The err_count signal exists only when MONITOR_ERR_COUNT_EN is defined.
interface counter_monitor_if
   import counter_mon_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
);

   logic             enable;
   logic             direction;
   logic [WIDTH-1:0] counter_in;
   logic             clear;
   logic [WIDTH-1:0] expected;
   logic             check_valid;
   logic             err;
   logic             err_sticky;
`ifdef MONITOR_ERR_COUNT_EN
   logic [ERR_COUNT_WIDTH-1:0] err_count;
`endif

`ifdef MONITOR_ERR_COUNT_EN
   // Side driving the observed counter and reading results
   modport master (
      output enable, direction, counter_in, clear,
      input  expected, check_valid, err, err_sticky, err_count
   );

   // Monitor side
   modport slave (
      input  enable, direction, counter_in, clear,
      output expected, check_valid, err, err_sticky, err_count
   );
`else
   // Side driving the observed counter and reading results
   modport master (
      output enable, direction, counter_in, clear,
      input  expected, check_valid, err, err_sticky
   );

   // Monitor side
   modport slave (
      input  enable, direction, counter_in, clear,
      output expected, check_valid, err, err_sticky
   );
`endif

endinterface

// File: rtl/counter_model.sv
// Reference next-value model of an up/down counter, modulo 2^WIDTH.
module counter_model
   import counter_mon_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic [WIDTH-1:0] value,
   input  logic             en,
   input  logic             dir,
   output logic [WIDTH-1:0] next_value_c
);

   // Step by one in the given direction when enabled; wrap is natural modulo arithmetic
   always_comb begin
      next_value_c = value;
      if (en) begin
         if (dir) begin
            next_value_c = value + WIDTH'(1);
         end else begin
            next_value_c = value - WIDTH'(1);
         end
      end
   end

endmodule

// File: rtl/counter_monitor.sv
// Counter monitor: predicts the observed counter from last cycle's sample and
// flags mismatches. Define MONITOR_ERR_COUNT_EN to add a saturating err_count.
module counter_monitor
   import counter_mon_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic            clk,
   input  logic            rst,
   counter_monitor_if.slave mon
);

   mon_state_e       state_q, state_d;
   logic             prev_en_q, prev_en_d;
   logic             prev_dir_q, prev_dir_d;
   logic [WIDTH-1:0] prev_ctr_q, prev_ctr_d;
   logic [WIDTH-1:0] expected_q, expected_d;
   logic             check_valid_q, check_valid_d;
   logic             err_q, err_d;
   logic             err_sticky_q, err_sticky_d;

   logic [WIDTH-1:0] pred_c;
   logic [WIDTH-1:0] ref_val_c;
   logic             cmp_en_c;
   logic             mismatch_c;

   // Prediction from the previous cycle's observed sample
   counter_model #(
      .WIDTH(WIDTH)
   ) u_model (
      .value       (prev_ctr_q),
      .en          (prev_en_q),
      .dir         (prev_dir_q),
      .next_value_c(pred_c)
   );

   // State and sample registers; reset discards all history
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= RST_CHK;
         prev_en_q     <= 1'b0;
         prev_dir_q    <= 1'b0;
         prev_ctr_q    <= '0;
         expected_q    <= '0;
         check_valid_q <= 1'b0;
         err_q         <= 1'b0;
         err_sticky_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         prev_en_q     <= prev_en_d;
         prev_dir_q    <= prev_dir_d;
         prev_ctr_q    <= prev_ctr_d;
         expected_q    <= expected_d;
         check_valid_q <= check_valid_d;
         err_q         <= err_d;
         err_sticky_q  <= err_sticky_d;
      end
   end

   // Next state, comparison and error flags; clear overrides the sticky flag and state
   always_comb begin
      state_d       = state_q;
      prev_en_d     = mon.enable;
      prev_dir_d    = mon.direction;
      prev_ctr_d    = mon.counter_in;
      ref_val_c     = '0;
      cmp_en_c      = 1'b0;
      err_sticky_d  = err_sticky_q;

      unique case (state_q)
         RST_CHK: begin
            ref_val_c = '0;
            cmp_en_c  = 1'b1;
            state_d   = TRACK;
         end
         TRACK: begin
            ref_val_c = pred_c;
            cmp_en_c  = 1'b1;
            state_d   = TRACK;
         end
         RESYNC: begin
            // No comparison: the observed value becomes the new baseline
            ref_val_c = mon.counter_in;
            cmp_en_c  = 1'b0;
            state_d   = TRACK;
         end
         default: begin
            state_d = RST_CHK;
         end
      endcase

      mismatch_c    = cmp_en_c && (mon.counter_in != ref_val_c);
      expected_d    = ref_val_c;
      check_valid_d = cmp_en_c;
      err_d         = mismatch_c;

      if (mon.clear) begin
         state_d      = RESYNC;
         err_sticky_d = 1'b0;
      end else if (mismatch_c) begin
         err_sticky_d = 1'b1;
      end
   end

   assign mon.expected    = expected_q;
   assign mon.check_valid = check_valid_q;
   assign mon.err         = err_q;
   assign mon.err_sticky  = err_sticky_q;

`ifdef MONITOR_ERR_COUNT_EN
   logic [ERR_COUNT_WIDTH-1:0] err_count_q, err_count_d;

   // Saturating mismatch counter register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_count_q <= '0;
      end else begin
         err_count_q <= err_count_d;
      end
   end

   // Count mismatches up to saturation; clear wins over a coincident mismatch
   always_comb begin
      err_count_d = err_count_q;
      if (mon.clear) begin
         err_count_d = '0;
      end else if (mismatch_c && (err_count_q != ERR_COUNT_MAX)) begin
         err_count_d = err_count_q + ERR_COUNT_WIDTH'(1);
      end
   end

   assign mon.err_count = err_count_q;
`endif

endmodule
